// File: rtl/lifi_regs_pkg.sv
// Register map, encodings and FSM state constants shared by the LiFi TX/RX control blocks.
package lifi_regs_pkg;

    // Register offsets within the 32-byte window
    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_STATUS = 5'h04;
    localparam logic [4:0] ADDR_DR00   = 5'h10;
    localparam logic [4:0] ADDR_DR01   = 5'h14;
    localparam logic [4:0] ADDR_DR02   = 5'h18;
    localparam logic [4:0] ADDR_DR03   = 5'h1C;

    // mod_type encodings
    localparam logic [1:0] MOD_BPSK    = 2'd0;
    localparam logic [1:0] MOD_QPSK    = 2'd1;
    localparam logic [1:0] MOD_16QAM   = 2'd2;
    localparam logic [1:0] MOD_16QAM_X = 2'd3;

    // AXI-lite write FSM states
    localparam logic [1:0] WRIDLE = 2'd0;
    localparam logic [1:0] WRDATA = 2'd1;
    localparam logic [1:0] WRRESP = 2'd2;

    // AXI-lite read FSM states
    localparam logic [0:0] RDIDLE = 1'b0;
    localparam logic [0:0] RDDATA = 1'b1;

    // Receive stream FSM states
    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_RECV = 2'd1;
    localparam logic [1:0] RX_DROP = 2'd2;

    // CTRL register layout, LSB first: mod_type, guard_interval, rx_en, irq_en
    typedef struct packed {
        logic       irq_en;
        logic       rx_en;
        logic [7:0] guard_interval;
        logic [1:0] mod_type;
    } ctrl_t;

    // Payload words per frame for a given modulation
    function automatic logic [2:0] mod_to_nwords(input logic [1:0] mod);
        case (mod)
            MOD_BPSK: return 3'd1;
            MOD_QPSK: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/axi_lifirx_control_if.sv
// AXI4-lite bus bundle for the LiFi RX control block.
interface axi_lifirx_control_if;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axi_lifirx_control_axi_lite_slave_if.sv
// AXI4-lite slave front end: single-outstanding write/read FSMs, address latch and byte mask.
module axi_lite_slave_if
    import lifi_regs_pkg::*;
#(
    parameter int unsigned C_ADDR_BITS = 5
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    axi_lifirx_control_if.slave    s_axi,
    output logic                   wr_en,
    output logic [C_ADDR_BITS-1:0] waddr,
    output logic [31:0]            wdata_masked,
    output logic [31:0]            wmask,
    output logic                   rd_en,
    output logic [C_ADDR_BITS-1:0] raddr,
    input  logic [31:0]            rdata
);

    logic [1:0]             wstate_q, wstate_d;
    logic [C_ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [0:0]             rstate_q, rstate_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   unused_addr;

    assign unused_addr = &{1'b0, s_axi.s_axi_awaddr[31:C_ADDR_BITS], s_axi.s_axi_araddr[31:C_ADDR_BITS]};

    assign s_axi.s_axi_awready = (wstate_q == WRIDLE);
    assign s_axi.s_axi_wready  = (wstate_q == WRDATA);
    assign s_axi.s_axi_bvalid  = (wstate_q == WRRESP);
    assign s_axi.s_axi_bresp   = 2'b00;
    assign s_axi.s_axi_arready = (rstate_q == RDIDLE);
    assign s_axi.s_axi_rvalid  = (rstate_q == RDDATA);
    assign s_axi.s_axi_rresp   = 2'b00;
    assign s_axi.s_axi_rdata   = rdata_q;

    assign wmask = {{8{s_axi.s_axi_wstrb[3]}}, {8{s_axi.s_axi_wstrb[2]}},
                    {8{s_axi.s_axi_wstrb[1]}}, {8{s_axi.s_axi_wstrb[0]}}};
    assign wdata_masked = s_axi.s_axi_wdata & wmask;
    assign wr_en = (wstate_q == WRDATA) && s_axi.s_axi_wvalid;
    assign waddr = waddr_q;
    assign rd_en = (rstate_q == RDIDLE) && s_axi.s_axi_arvalid;
    assign raddr = s_axi.s_axi_araddr[C_ADDR_BITS-1:0];

    // Write channel sequencing: AW, then W, then B
    always_comb begin
        wstate_d = wstate_q;
        waddr_d  = waddr_q;
        case (wstate_q)
            WRIDLE: if (s_axi.s_axi_awvalid) begin
                waddr_d  = s_axi.s_axi_awaddr[C_ADDR_BITS-1:0];
                wstate_d = WRDATA;
            end
            WRDATA: if (s_axi.s_axi_wvalid) wstate_d = WRRESP;
            WRRESP: if (s_axi.s_axi_bready) wstate_d = WRIDLE;
            default: wstate_d = WRIDLE;
        endcase
    end

    // Read channel sequencing; read data captured at the AR handshake
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            RDIDLE: if (s_axi.s_axi_arvalid) begin
                rdata_d  = rdata;
                rstate_d = RDDATA;
            end
            RDDATA: if (s_axi.s_axi_rready) rstate_d = RDIDLE;
            default: rstate_d = RDIDLE;
        endcase
    end

    // State and latch registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate_q <= WRIDLE;
            waddr_q  <= '0;
            rstate_q <= RDIDLE;
            rdata_q  <= '0;
        end else begin
            wstate_q <= wstate_d;
            waddr_q  <= waddr_d;
            rstate_q <= rstate_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: rtl/axi_lifirx_control.sv
// LiFi OFDM RX control: CTRL/STATUS/DATA registers and single-frame capture from the demapper stream.
module axi_lifirx_control
    import lifi_regs_pkg::*;
#(
    parameter int unsigned C_ADDR_BITS = 5
) (
    input  logic                aclk,
    input  logic                aresetn,
    axi_lifirx_control_if.slave s_axi,
    input  logic [31:0]         s_axis_tdata,
    input  logic                s_axis_tvalid,
    input  logic                s_axis_tlast,
    output logic                s_axis_tready,
    output logic [1:0]          mod_type,
    output logic [7:0]          guard_interval,
    output logic                irq
);

    logic                   wr_en, rd_en;
    logic [C_ADDR_BITS-1:0] waddr, raddr;
    logic [31:0]            wdata_masked, wmask, rd_mux, ctrl_wr;

    ctrl_t       ctrl_q, ctrl_d;
    logic        fv_q, fv_d, ov_q, ov_d, le_q, le_d;
    logic [1:0]  rx_state_q, rx_state_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  nw_lat_q, nw_lat_d;
    logic [2:0]  nw_new;
    logic        last_cnt;
    logic [31:0] data_q [4];
    logic [31:0] data_d [4];
    logic        busy;
    logic        unused_top;

    axi_lite_slave_if #(.C_ADDR_BITS(C_ADDR_BITS)) u_axi (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axi        (s_axi),
        .wr_en        (wr_en),
        .waddr        (waddr),
        .wdata_masked (wdata_masked),
        .wmask        (wmask),
        .rd_en        (rd_en),
        .raddr        (raddr),
        .rdata        (rd_mux)
    );

    assign busy           = (rx_state_q != RX_IDLE);
    assign s_axis_tready  = ctrl_q.rx_en;
    assign mod_type       = ctrl_q.mod_type;
    assign guard_interval = ctrl_q.guard_interval;
    assign irq            = fv_q & ctrl_q.irq_en;
    assign ctrl_wr        = ({20'b0, ctrl_q} & ~wmask) | wdata_masked;
    assign unused_top     = &{1'b0, ctrl_wr[31:12], rd_en};

    // Byte-masked CTRL write
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_en && waddr == C_ADDR_BITS'(ADDR_CTRL))
            ctrl_d = ctrl_t'(ctrl_wr[11:0]);
    end

    // Frame capture FSM and STATUS bits; hardware sets are applied after W1C so a set wins
    always_comb begin
        fv_d       = fv_q;
        ov_d       = ov_q;
        le_d       = le_q;
        rx_state_d = rx_state_q;
        wr_ptr_d   = wr_ptr_q;
        nw_lat_d   = nw_lat_q;
        data_d     = data_q;
        nw_new     = mod_to_nwords(ctrl_q.mod_type);
        last_cnt   = ({1'b0, wr_ptr_q} == (nw_lat_q - 3'd1));

        if (wr_en && waddr == C_ADDR_BITS'(ADDR_STATUS)) begin
            if (wdata_masked[0]) fv_d = 1'b0;
            if (wdata_masked[1]) ov_d = 1'b0;
            if (wdata_masked[2]) le_d = 1'b0;
        end

        if (!ctrl_q.rx_en) begin
            rx_state_d = RX_IDLE;
            wr_ptr_d   = '0;
        end else if (s_axis_tvalid) begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!fv_q) begin
                        data_d[0] = s_axis_tdata;
                        nw_lat_d  = nw_new;
                        if (nw_new == 3'd1 || s_axis_tlast) begin
                            fv_d     = 1'b1;
                            wr_ptr_d = '0;
                            if (nw_new == 3'd1 ? !s_axis_tlast : 1'b1) le_d = 1'b1;
                        end else begin
                            wr_ptr_d   = 2'd1;
                            rx_state_d = RX_RECV;
                        end
                    end else begin
                        ov_d       = 1'b1;
                        rx_state_d = RX_DROP;
                    end
                end
                RX_RECV: begin
                    data_d[wr_ptr_q] = s_axis_tdata;
                    if (last_cnt || s_axis_tlast) begin
                        fv_d       = 1'b1;
                        if (last_cnt != s_axis_tlast) le_d = 1'b1;
                        wr_ptr_d   = '0;
                        rx_state_d = RX_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 2'd1;
                    end
                end
                RX_DROP: if (s_axis_tlast) rx_state_d = RX_IDLE;
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    // Read-data mux; unmapped offsets read as zero
    always_comb begin
        rd_mux = '0;
        case (raddr)
            C_ADDR_BITS'(ADDR_CTRL):   rd_mux = {20'b0, ctrl_q};
            C_ADDR_BITS'(ADDR_STATUS): rd_mux = {28'b0, busy, le_q, ov_q, fv_q};
            C_ADDR_BITS'(ADDR_DR00):   rd_mux = data_q[0];
            C_ADDR_BITS'(ADDR_DR01):   rd_mux = data_q[1];
            C_ADDR_BITS'(ADDR_DR02):   rd_mux = data_q[2];
            C_ADDR_BITS'(ADDR_DR03):   rd_mux = data_q[3];
            default:                   rd_mux = '0;
        endcase
    end

    // Register state
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ctrl_q     <= '0;
            fv_q       <= 1'b0;
            ov_q       <= 1'b0;
            le_q       <= 1'b0;
            rx_state_q <= RX_IDLE;
            wr_ptr_q   <= '0;
            nw_lat_q   <= 3'd1;
            data_q     <= '{default: '0};
        end else begin
            ctrl_q     <= ctrl_d;
            fv_q       <= fv_d;
            ov_q       <= ov_d;
            le_q       <= le_d;
            rx_state_q <= rx_state_d;
            wr_ptr_q   <= wr_ptr_d;
            nw_lat_q   <= nw_lat_d;
            data_q     <= data_d;
        end
    end

endmodule

// File: tb/tb_axi_lifirx_control.sv
// Self-checking bench for axi_lifirx_control: register vectors, directed frame sequences, random stream.
module tb_axi_lifirx_control;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [1:0]  mod_type;
    logic [7:0]  guard_interval;
    logic        irq;

    int checks = 0;
    int errors = 0;

    axi_lifirx_control_if bus ();

    axi_lifirx_control #(.C_ADDR_BITS(5)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axi          (bus),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .mod_type       (mod_type),
        .guard_interval (guard_interval),
        .irq            (irq)
    );

    always #5 aclk = ~aclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [11:0] m_ctrl;
    logic        m_fv, m_ov, m_le, m_drop;
    logic [31:0] m_data [4];
    logic [31:0] m_cur [$];
    int          m_len;

    function automatic int nwords(input logic [1:0] m);
        return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_status();
        logic busy;
        busy = (m_cur.size() != 0) || m_drop;
        return {28'b0, busy, m_le, m_ov, m_fv};
    endfunction

    function automatic void model_reset();
        m_ctrl = '0; m_fv = 0; m_ov = 0; m_le = 0; m_drop = 0; m_len = 1;
        m_cur.delete();
        for (int i = 0; i < 4; i++) m_data[i] = '0;
    endfunction

    function automatic void model_beat(input logic [31:0] d, input logic last);
        if (!m_ctrl[10]) return;
        if (m_drop) begin
            if (last) m_drop = 0;
        end else if (m_cur.size() == 0 && m_fv) begin
            m_ov = 1; m_drop = 1;
        end else begin
            if (m_cur.size() == 0) m_len = nwords(m_ctrl[1:0]);
            m_data[m_cur.size()] = d;
            m_cur.push_back(d);
            if (m_cur.size() == m_len || last) begin
                m_fv = 1;
                if (m_cur.size() != m_len || !last) m_le = 1;
                m_cur.delete();
            end
        end
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (a[4:0] == 5'h00) begin
            m_ctrl = 12'((({20'b0, m_ctrl} & ~mask) | (d & mask)));
            if (!m_ctrl[10]) begin m_cur.delete(); m_drop = 0; end
        end else if (a[4:0] == 5'h04 && s[0]) begin
            if (d[0]) m_fv = 0;
            if (d[1]) m_ov = 0;
            if (d[2]) m_le = 0;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_hi(input string name, ref logic sig);
        int n = 0;
        while (sig !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL %s: handshake timeout got 0 expected 1", name);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge aclk);
        bus.s_axi_awaddr = a; bus.s_axi_awvalid = 1'b1;
        wait_hi("awready", bus.s_axi_awready);
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = d; bus.s_axi_wstrb = s; bus.s_axi_wvalid = 1'b1;
        wait_hi("wready", bus.s_axi_wready);
        @(negedge aclk);
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
        wait_hi("bvalid", bus.s_axi_bvalid);
        check("bresp", {30'b0, bus.s_axi_bresp}, 32'h0);
        @(negedge aclk);
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge aclk);
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        wait_hi("arready", bus.s_axi_arready);
        @(negedge aclk);
        bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b1;
        wait_hi("rvalid", bus.s_axi_rvalid);
        d = bus.s_axi_rdata;
        check("rresp", {30'b0, bus.s_axi_rresp}, 32'h0);
        @(negedge aclk);
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        axi_write(a, d, s);
        model_write(a, d, s);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        @(negedge aclk);
        s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = last;
        @(negedge aclk);
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        model_beat(d, last);
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        axi_read(a, v);
        check(name, v, exp);
    endtask

    task automatic chk_pins();
        check("irq", {31'b0, irq}, {31'b0, m_fv & m_ctrl[11]});
        check("tready", {31'b0, s_axis_tready}, {31'b0, m_ctrl[10]});
        check("mod_type", {30'b0, mod_type}, {30'b0, m_ctrl[1:0]});
        check("guard", {24'b0, guard_interval}, {24'b0, m_ctrl[9:2]});
    endtask

    task automatic chk_model_regs();
        chk_reg("status", 32'h04, m_status());
        for (int i = 0; i < 4; i++) chk_reg("data", 32'h10 + 32'(i * 4), m_data[i]);
        chk_pins();
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [31:0] v;
        int r;

        vecs[0] = '{32'h00, 32'hFFFF_FFFF, 4'b0001, 32'h00, 32'h0000_00FF};
        vecs[1] = '{32'h00, 32'hFFFF_F3FF, 4'b0010, 32'h00, 32'h0000_03FF};
        vecs[2] = '{32'h00, 32'h1234_5678, 4'b1100, 32'h00, 32'h0000_03FF};
        vecs[3] = '{32'h00, 32'h0000_0000, 4'b1111, 32'h00, 32'h0000_0000};
        vecs[4] = '{32'h08, 32'hDEAD_BEEF, 4'b1111, 32'h08, 32'h0000_0000};
        vecs[5] = '{32'h10, 32'hFFFF_FFFF, 4'b1111, 32'h10, 32'h0000_0000};
        vecs[6] = '{32'h1C, 32'hCAFE_F00D, 4'b1111, 32'h1C, 32'h0000_0000};
        vecs[7] = '{32'h0C, 32'h0000_0001, 4'b1111, 32'h0C, 32'h0000_0000};

        aresetn = 1'b0;
        bus.s_axi_awaddr = '0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = '0;
        bus.s_axi_wstrb = '0; bus.s_axi_wvalid = 0; bus.s_axi_bready = 0;
        bus.s_axi_araddr = '0; bus.s_axi_arvalid = 0; bus.s_axi_rready = 0;
        s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
        model_reset();
        repeat (4) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // reset state
        check("rst_awready", {31'b0, bus.s_axi_awready}, 32'h1);
        check("rst_arready", {31'b0, bus.s_axi_arready}, 32'h1);
        check("rst_bvalid", {31'b0, bus.s_axi_bvalid}, 32'h0);
        check("rst_rvalid", {31'b0, bus.s_axi_rvalid}, 32'h0);
        check("rst_rdata", bus.s_axi_rdata, 32'h0);
        check("rst_tready", {31'b0, s_axis_tready}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        chk_reg("rst_ctrl", 32'h00, 32'h0);
        chk_reg("rst_status", 32'h04, 32'h0);
        chk_reg("rst_data0", 32'h10, 32'h0);

        // register access vectors
        for (int i = 0; i < 8; i++) begin
            reg_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            chk_reg($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
        chk_pins();

        // QPSK frame, irq, W1C
        reg_write(32'h00, 32'h0000_0C01, 4'hF);
        send_beat(32'hA5A5_A5A5, 1'b0);
        send_beat(32'h5A5A_5A5A, 1'b1);
        chk_reg("qpsk_status", 32'h04, 32'h1);
        chk_reg("qpsk_d0", 32'h10, 32'hA5A5_A5A5);
        chk_reg("qpsk_d1", 32'h14, 32'h5A5A_5A5A);
        check("qpsk_irq", {31'b0, irq}, 32'h1);
        reg_write(32'h04, 32'h1, 4'hF);
        check("w1c_irq", {31'b0, irq}, 32'h0);
        chk_reg("w1c_status", 32'h04, 32'h0);

        // 16QAM with gaps between beats
        reg_write(32'h00, 32'h0000_0C02, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            send_beat(32'(i), i == 4);
            repeat (i) @(negedge aclk);
        end
        chk_model_regs();
        chk_reg("qam_status", 32'h04, 32'h1);
        chk_reg("qam_d3", 32'h1C, 32'h4);
        reg_write(32'h04, 32'h7, 4'hF);

        // 16QAM short frame: tlast on 2nd word
        send_beat(32'hB1, 1'b0);
        send_beat(32'hB2, 1'b1);
        chk_reg("short_status", 32'h04, 32'h5);
        chk_reg("short_d1", 32'h14, 32'hB2);
        chk_reg("short_d2", 32'h18, 32'h3);
        chk_model_regs();
        reg_write(32'h04, 32'h7, 4'hF);

        // overrun: second frame while the first is still unread
        reg_write(32'h00, 32'h0000_0C01, 4'hF);
        send_beat(32'hC1, 1'b0);
        send_beat(32'hC2, 1'b1);
        send_beat(32'hD1, 1'b0);
        chk_reg("drop_busy", 32'h04, 32'hB);
        send_beat(32'hD2, 1'b1);
        chk_reg("ovr_status", 32'h04, 32'h3);
        chk_reg("ovr_d0", 32'h10, 32'hC1);
        chk_model_regs();
        reg_write(32'h04, 32'h7, 4'hF);

        // mod_type change mid-frame applies to the following frame
        send_beat(32'hE1, 1'b0);
        reg_write(32'h00, 32'h0000_0C00, 4'hF);
        chk_reg("mid_busy", 32'h04, 32'h8);
        send_beat(32'hE2, 1'b1);
        chk_reg("mid_status", 32'h04, 32'h1);
        chk_reg("mid_d1", 32'h14, 32'hE2);
        reg_write(32'h04, 32'h1, 4'hF);
        send_beat(32'hF1, 1'b1);
        chk_reg("bpsk_status", 32'h04, 32'h1);
        chk_reg("bpsk_d0", 32'h10, 32'hF1);
        reg_write(32'h04, 32'h7, 4'hF);

        // rx_en cleared mid-frame
        reg_write(32'h00, 32'h0000_0C02, 4'hF);
        send_beat(32'h31, 1'b0);
        send_beat(32'h32, 1'b0);
        chk_reg("rxen_busy", 32'h04, 32'h8);
        reg_write(32'h00, 32'h0000_0802, 4'hF);
        chk_reg("rxen_idle", 32'h04, 32'h0);
        chk_reg("rxen_d0", 32'h10, 32'h31);
        chk_pins();
        reg_write(32'h00, 32'h0000_0C02, 4'hF);
        for (int i = 0; i < 4; i++) send_beat(32'h41 + 32'(i), i == 3);
        chk_model_regs();
        reg_write(32'h04, 32'h7, 4'hF);

        // W1C and hardware set of frame_valid on the same edge: set wins
        reg_write(32'h00, 32'h0000_0C01, 4'hF);
        send_beat(32'h11, 1'b0);
        @(negedge aclk);
        bus.s_axi_awaddr = 32'h04; bus.s_axi_awvalid = 1'b1;
        @(negedge aclk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = 32'h7; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
        s_axis_tdata = 32'h22; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
        @(negedge aclk);
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b1;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        wait_hi("bvalid", bus.s_axi_bvalid);
        @(negedge aclk);
        bus.s_axi_bready = 1'b0;
        model_write(32'h04, 32'h7, 4'hF);
        model_beat(32'h22, 1'b1);
        chk_reg("setwins_status", 32'h04, 32'h1);
        chk_reg("setwins_d1", 32'h14, 32'h22);
        reg_write(32'h04, 32'h7, 4'hF);

        // randomized stream against the model
        reg_write(32'h00, 32'h0000_0C00 | 32'($urandom_range(0, 3)), 4'hF);
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                send_beat($urandom, $urandom_range(0, 3) == 0);
            end else if (r < 65) begin
                @(negedge aclk);
            end else if (r < 78) begin
                chk_reg("rnd_status", 32'h04, m_status());
            end else if (r < 86) begin
                int k = $urandom_range(0, 3);
                chk_reg("rnd_data", 32'h10 + 32'(k * 4), m_data[k]);
            end else if (r < 93) begin
                reg_write(32'h04, 32'($urandom_range(0, 7)), 4'hF);
            end else if (r < 98) begin
                v = {20'b0, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom), 2'($urandom)};
                reg_write(32'h00, v, 4'hF);
            end else begin
                reg_write(32'h00, {20'b0, m_ctrl[11], 1'b0, m_ctrl[9:0]}, 4'hF);
            end
            chk_pins();
        end
        chk_model_regs();
        chk_reg("final_ctrl", 32'h00, {20'b0, m_ctrl});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
